// File: rtl/rvs192_hazard_ctrl_if.sv
// Hazard controller port bundle: decoded ID fields and pipeline events in,
// PC/IF-ID/ID-EX controls and forwarding selects out.
interface rvs192_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_wen;
    logic                  id_cpu_read;
    logic                  ex_redirect;
    logic                  mem_busy;
    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_bubble;
    logic                  ifid_flush;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_wen, id_cpu_read, ex_redirect, mem_busy,
        input  pc_en, ifid_en, idex_bubble, ifid_flush, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_wen, id_cpu_read, ex_redirect, mem_busy,
        output pc_en, ifid_en, idex_bubble, ifid_flush, fwd_a, fwd_b
    );
endinterface

// File: rtl/rvs192_hazard_ctrl.sv
// RVS192 ID-stage hazard controller: EX/MEM writer scoreboard, load-use stall,
// redirect flush sequencing, cache-miss freeze and operand forwarding selects.
module rvs192_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned REG_ADDR_W   = 5
) (
    input logic                clk,
    input logic                rst_n,
    rvs192_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {StRun, StFlush, StHold} state_e;

    state_e state_q, state_d, saved_q, saved_d, cur;
    logic [1:0] cnt_q, cnt_d;

    logic                  ex_v_q, ex_ld_q, mem_v_q, mem_ld_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q;

    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic load_use, flushing, issue;

    always_comb begin
        rs1_ex  = hz.id_valid & hz.id_rs1_used & (hz.id_rs1 != '0) & ex_v_q &
                  (hz.id_rs1 == ex_rd_q);
        rs2_ex  = hz.id_valid & hz.id_rs2_used & (hz.id_rs2 != '0) & ex_v_q &
                  (hz.id_rs2 == ex_rd_q);
        rs1_mem = hz.id_valid & hz.id_rs1_used & (hz.id_rs1 != '0) & mem_v_q &
                  (hz.id_rs1 == mem_rd_q);
        rs2_mem = hz.id_valid & hz.id_rs2_used & (hz.id_rs2 != '0) & mem_v_q &
                  (hz.id_rs2 == mem_rd_q);
        load_use = (rs1_ex | rs2_ex) & ex_ld_q;
        // Releasing from HOLD behaves as the saved state in the same cycle.
        cur = (state_q == StHold) ? saved_q : state_q;
        flushing = (cur == StFlush) | hz.ex_redirect;
    end

    always_comb begin
        hz.pc_en       = 1'b0;
        hz.ifid_en     = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.fwd_a       = 2'b00;
        hz.fwd_b       = 2'b00;
        if (!rst_n) begin
            hz.idex_bubble = 1'b1;
            hz.ifid_flush  = 1'b1;
        end else if (hz.mem_busy) begin
            hz.pc_en = 1'b0;
        end else if (flushing) begin
            hz.pc_en       = 1'b1;
            hz.ifid_en     = 1'b1;
            hz.idex_bubble = 1'b1;
            hz.ifid_flush  = 1'b1;
        end else if (load_use) begin
            hz.idex_bubble = 1'b1;
        end else begin
            hz.pc_en   = 1'b1;
            hz.ifid_en = 1'b1;
        end
        // A load match in EX shadows any older MEM match on that operand.
        if (!hz.idex_bubble) begin
            if (rs1_ex)       hz.fwd_a = ex_ld_q ? 2'b00 : 2'b01;
            else if (rs1_mem) hz.fwd_a = 2'b10;
            if (rs2_ex)       hz.fwd_b = ex_ld_q ? 2'b00 : 2'b01;
            else if (rs2_mem) hz.fwd_b = 2'b10;
        end
        issue = hz.id_valid & hz.id_reg_wen & (hz.id_rd != '0) &
                ~hz.idex_bubble & ~hz.ifid_flush;
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        if (hz.mem_busy) begin
            state_d = StHold;
            saved_d = cur;
        end else begin
            unique case (cur)
                StRun: begin
                    state_d = StRun;
                    if (hz.ex_redirect && FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        cnt_d   = 2'(FLUSH_CYCLES - 1);
                    end
                end
                StFlush: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = StRun;
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = StFlush;
                        cnt_d   = cnt_q - 2'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            saved_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= '0;
            ex_ld_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_ld_q <= 1'b0;
        end else if (!hz.mem_busy) begin
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_ld_q <= ex_ld_q;
            ex_v_q   <= issue;
            ex_rd_q  <= hz.id_rd;
            ex_ld_q  <= hz.id_cpu_read;
        end
    end
endmodule

// File: tb/tb_rvs192_hazard_ctrl.sv
// Self-checking bench for rvs192_hazard_ctrl: directed scenarios plus random
// traffic against an in-flight-instruction reference model.
module tb_rvs192_hazard_ctrl;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    rvs192_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

    rvs192_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    // Reference model: writers in flight and flush cycles still owed.
    bit       m_ex_v, m_ex_ld, m_mem_v, m_mem_ld;
    bit [4:0] m_ex_rd, m_mem_rd;
    int       m_flush_left;
    bit       e_pc, e_ifid, e_bub, e_fl, e_ifid_chk;
    bit [1:0] e_fa, e_fb;

    function automatic bit hit(bit [4:0] rs, bit used, bit v, bit [4:0] rd);
        return hz.id_valid && used && rs != 0 && v && rs == rd;
    endfunction

    function automatic bit [1:0] fsel(bit [4:0] rs, bit used);
        if (hit(rs, used, m_ex_v, m_ex_rd)) return m_ex_ld ? 2'd0 : 2'd1;
        if (hit(rs, used, m_mem_v, m_mem_rd)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic calc();
        bit lu;
        lu = m_ex_ld && (hit(hz.id_rs1, hz.id_rs1_used, m_ex_v, m_ex_rd) ||
                         hit(hz.id_rs2, hz.id_rs2_used, m_ex_v, m_ex_rd));
        e_ifid_chk = 1;
        e_fa = fsel(hz.id_rs1, hz.id_rs1_used);
        e_fb = fsel(hz.id_rs2, hz.id_rs2_used);
        if (!rst_n) begin
            {e_pc, e_ifid, e_bub, e_fl} = 4'b0011;
            e_fa = 0; e_fb = 0;
        end else if (hz.mem_busy) begin
            {e_pc, e_ifid, e_bub, e_fl} = 4'b0000;
        end else if (m_flush_left > 0 || hz.ex_redirect) begin
            {e_pc, e_ifid, e_bub, e_fl} = 4'b1011;
            e_ifid_chk = 0;
            e_fa = 0; e_fb = 0;
        end else if (lu) begin
            {e_pc, e_ifid, e_bub, e_fl} = 4'b0010;
            e_fa = 0; e_fb = 0;
        end else begin
            {e_pc, e_ifid, e_bub, e_fl} = 4'b1100;
        end
    endtask

    task automatic advance();
        bit issue;
        calc();
        @(posedge clk);
        if (!rst_n) begin
            {m_ex_v, m_ex_ld, m_mem_v, m_mem_ld} = '0;
            m_ex_rd = 0; m_mem_rd = 0; m_flush_left = 0;
        end else if (!hz.mem_busy) begin
            issue = hz.id_valid && hz.id_reg_wen && hz.id_rd != 0 && !e_bub && !e_fl;
            m_mem_v = m_ex_v; m_mem_rd = m_ex_rd; m_mem_ld = m_ex_ld;
            m_ex_v = issue; m_ex_rd = hz.id_rd; m_ex_ld = hz.id_cpu_read;
            if (m_flush_left > 0) m_flush_left--;
            else if (hz.ex_redirect) m_flush_left = FC - 1;
        end
        #1;
    endtask

    task automatic set_id(bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                          bit [4:0] rd, bit wen, bit ld);
        hz.id_valid = v; hz.id_rs1 = rs1; hz.id_rs1_used = u1;
        hz.id_rs2 = rs2; hz.id_rs2_used = u2; hz.id_rd = rd;
        hz.id_reg_wen = wen; hz.id_cpu_read = ld;
    endtask

    task automatic set_ctl(bit redir, bit busy);
        hz.ex_redirect = redir; hz.mem_busy = busy;
    endtask

    task automatic idle2();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        advance();
        advance();
    endtask

    // Compare {pc_en, ifid_en, idex_bubble, ifid_flush} against a constant.
    `define CHK_CTL(NAME, EXP) \
        begin \
            @(negedge clk); total++; \
            if ({hz.pc_en, hz.ifid_en, hz.idex_bubble, hz.ifid_flush} !== 4'(EXP)) begin \
                bad++; \
                $display("FAIL %s: ctl pc/ifid/bub/flush got %b want %b", NAME, \
                         {hz.pc_en, hz.ifid_en, hz.idex_bubble, hz.ifid_flush}, 4'(EXP)); \
            end \
        end

    task automatic test_reset();
        rst_n = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        `CHK_CTL("reset_ctl", 4'b0011)
        total++;
        if ({hz.fwd_a, hz.fwd_b} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_fwd: got %b want 0000", {hz.fwd_a, hz.fwd_b});
        end
        advance();
        rst_n = 1;
        advance();
    endtask

    task automatic test_load_use();
        idle2();
        set_id(1, 1, 1, 0, 0, 5, 1, 1);          // LW x5,0(x1)
        `CHK_CTL("lu_issue", 4'b1100)
        advance();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);          // ADD x6,x5,x1
        `CHK_CTL("lu_stall", 4'b0010)
        advance();
        `CHK_CTL("lu_resume", 4'b1100)
        total++;
        if (hz.fwd_a !== 2'b10 || hz.fwd_b !== 2'b00) begin
            bad++;
            $display("FAIL lu_fwd: got a=%b b=%b want a=10 b=00", hz.fwd_a, hz.fwd_b);
        end
        advance();
    endtask

    task automatic test_fwd_priority();
        bit [4:0] second[2] = '{5'd3, 5'd4};
        bit [1:0] want[2] = '{2'b01, 2'b10};
        for (int i = 0; i < 2; i++) begin
            idle2();
            set_id(1, 1, 1, 0, 0, 3, 1, 0);
            advance();
            set_id(1, 1, 1, 0, 0, second[i], 1, 0);
            advance();
            set_id(1, 3, 1, 0, 0, 8, 1, 0);
            @(negedge clk);
            total++;
            if (hz.fwd_a !== want[i] || hz.pc_en !== 1'b1) begin
                bad++;
                $display("FAIL fwd_prio%0d: got fwd_a=%b pc_en=%b want fwd_a=%b pc_en=1",
                         i, hz.fwd_a, hz.pc_en, want[i]);
            end
        end
        advance();
    endtask

    task automatic test_x0_unused();
        idle2();
        set_id(1, 1, 1, 0, 0, 0, 1, 0);          // ADDI x0
        advance();
        set_id(1, 0, 1, 0, 1, 9, 1, 0);
        `CHK_CTL("x0_ctl", 4'b1100)
        total++;
        if ({hz.fwd_a, hz.fwd_b} !== 4'b0000) begin
            bad++;
            $display("FAIL x0_fwd: got %b want 0000", {hz.fwd_a, hz.fwd_b});
        end
        advance();
        idle2();
        set_id(1, 1, 1, 0, 0, 7, 1, 1);          // LW x7
        advance();
        set_id(1, 7, 0, 7, 0, 10, 1, 0);         // LUI with stale rs fields = x7
        `CHK_CTL("unused_ctl", 4'b1100)
        total++;
        if ({hz.fwd_a, hz.fwd_b} !== 4'b0000) begin
            bad++;
            $display("FAIL unused_fwd: got %b want 0000", {hz.fwd_a, hz.fwd_b});
        end
        advance();
    endtask

    task automatic test_redirect();
        idle2();
        set_id(1, 1, 1, 0, 0, 5, 1, 1);          // LW x5
        advance();
        set_id(1, 5, 1, 0, 0, 6, 1, 0);          // load-use match, but redirect
        set_ctl(1, 0);
        @(negedge clk);
        total++;
        if ({hz.pc_en, hz.idex_bubble, hz.ifid_flush} !== 3'b111) begin
            bad++;
            $display("FAIL redir_first: pc/bub/flush got %b want 111",
                     {hz.pc_en, hz.idex_bubble, hz.ifid_flush});
        end
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        @(negedge clk);
        total++;
        if ({hz.pc_en, hz.idex_bubble, hz.ifid_flush} !== 3'b111) begin
            bad++;
            $display("FAIL redir_second: pc/bub/flush got %b want 111",
                     {hz.pc_en, hz.idex_bubble, hz.ifid_flush});
        end
        advance();
        `CHK_CTL("redir_back_run", 4'b1100)
        advance();
    endtask

    task automatic test_cache_miss();
        idle2();
        set_id(1, 1, 1, 0, 0, 3, 1, 0);          // ADDI x3
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(1, 0);
        advance();                               // now FLUSH with one cycle left
        set_id(1, 3, 1, 0, 0, 9, 1, 0);
        set_ctl(0, 1);
        for (int i = 0; i < 4; i++) begin
            `CHK_CTL("miss_hold", 4'b0000)
            total++;
            if (hz.fwd_a !== 2'b10) begin
                bad++;
                $display("FAIL miss_slot%0d: fwd_a got %b want 10", i, hz.fwd_a);
            end
            advance();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        `CHK_CTL("miss_last_flush", 4'b1111)
        advance();
        `CHK_CTL("miss_run", 4'b1100)
        advance();
    endtask

    task automatic test_reset_mid();
        idle2();
        set_id(1, 1, 1, 0, 0, 3, 1, 0);
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(1, 0);
        advance();
        set_ctl(0, 0);
        set_id(1, 3, 1, 0, 0, 8, 1, 0);
        rst_n = 0;
        #1;
        total++;
        if ({hz.pc_en, hz.ifid_en, hz.idex_bubble, hz.ifid_flush, hz.fwd_a} !== 6'b001100) begin
            bad++;
            $display("FAIL rstmid_now: got %b want 001100",
                     {hz.pc_en, hz.ifid_en, hz.idex_bubble, hz.ifid_flush, hz.fwd_a});
        end
        advance();
        rst_n = 1;
        `CHK_CTL("rstmid_run", 4'b1100)
        total++;
        if (hz.fwd_a !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_slots: fwd_a got %b want 00", hz.fwd_a);
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), $urandom_range(0, 2) == 0);
            set_ctl(m_flush_left == 0 && $urandom_range(0, 9) == 0,
                    $urandom_range(0, 6) == 0);
            @(negedge clk);
            calc();
            total++;
            if ({hz.pc_en, hz.idex_bubble, hz.ifid_flush, hz.fwd_a, hz.fwd_b} !==
                    {e_pc, e_bub, e_fl, e_fa, e_fb} ||
                    (e_ifid_chk && hz.ifid_en !== e_ifid)) begin
                bad++;
                $display("FAIL rand%0d: pc/ifid/bub/fl/fa/fb got %b%b%b%b %b %b want %b%b%b%b %b %b",
                         n, hz.pc_en, hz.ifid_en, hz.idex_bubble, hz.ifid_flush, hz.fwd_a,
                         hz.fwd_b, e_pc, e_ifid, e_bub, e_fl, e_fa, e_fb);
            end
            advance();
        end
    endtask

    initial begin
        m_flush_left = 0;
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_x0_unused();
        test_redirect();
        test_cache_miss();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rvs192_hazard_ctrl.md
# rvs192_hazard_ctrl

Pipeline hazard controller for the RVS192 five-stage core, sitting next to the instruction decoder in the ID stage. It takes the decoded register fields and control bits of the instruction in ID and keeps a two-slot scoreboard of in-flight writers (EX and MEM). From these it drives PC/IF-ID enables, bubble insertion, flush, and operand-forwarding selects. It sequences load-use stalls, taken-branch/jump flushes and data-cache miss freezes.

## Interface

- FLUSH_CYCLES, 1, cycles (1..3) IF/ID is squashed after an EX redirect
- REG_ADDR_W, 5, register index width
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source registers from decoder
- id_rs1_used, id_rs2_used  in  1  source actually read (0 for LUI/AUIPC/JAL; rs2 0 for I/L/JALR)
- id_rd  in  REG_ADDR_W  destination register
- id_reg_wen  in  1  decoded reg_wen
- id_cpu_read  in  1  decoded cpu_read (load)
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR
- mem_busy  in  1  data cache miss; whole pipeline frozen
- pc_en  out  1  PC register enable
- ifid_en  out  1  IF/ID register enable
- idex_bubble  out  1  load NOP (all control zero) into ID/EX
- ifid_flush  out  1  clear IF/ID to NOP
- fwd_a, fwd_b  out  2  operand source for ID instruction: 00 regfile, 01 EX/MEM result, 10 MEM/WB result

## Operation

- Scoreboard slots EX{v,rd,load} and MEM{v,rd,load}; reset all zero. Update only when mem_busy=0: MEM<=EX; EX<=issue, where issue.v = id_valid & id_reg_wen & (id_rd!=0) & no stall & no flush this cycle, rd=id_rd, load=id_cpu_read.
- Match(rs, slot) = slot.v & rs==slot.rd & rs!=0 & rsN_used & id_valid.
- Load-use: Match(rs1|rs2, EX) with EX.load -> pc_en=0, ifid_en=0, idex_bubble=1 for one cycle; next cycle the load is in MEM and a MEM match forwards via 10.
- Forwarding per operand: EX match (non-load) -> 01; else MEM match -> 10; else 00. EX match takes priority over MEM. fwd forced 00 when idex_bubble=1.
- FSM states RUN, FLUSH, HOLD. Priority: mem_busy > ex_redirect > load-use.
  - Any state, mem_busy=1 -> HOLD: pc_en=0, ifid_en=0, idex_bubble=0, ifid_flush=0, scoreboard frozen. ex_redirect ignored (EX frozen, so it stays asserted). On mem_busy=0 return to the saved state (RUN or FLUSH, counter kept).
  - RUN, ex_redirect=1: pc_en=1 (loads target), ifid_flush=1, idex_bubble=1. If FLUSH_CYCLES>1, go FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay RUN.
  - FLUSH: ifid_flush=1, idex_bubble=1, pc_en=1; cnt decrements; at cnt==1 return to RUN. A new ex_redirect cannot occur (EX holds bubbles).
  - RUN, no event: pc_en=1, ifid_en=1, others 0.
- Redirect and load-use in the same cycle: redirect wins. The ID instruction is squashed, so no stall occurs.
- Bubbled or flushed ID instructions never enter the scoreboard.

## Timing

- All outputs are combinational from registered state plus current inputs. Zero-cycle latency from inputs to outputs.
- Registers (state, cnt, saved state, slots) use asynchronous reset to RUN/0/invalid.
- While rst_n=0: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=1, fwd_a=fwd_b=00.
- Reset asserted mid-FLUSH or mid-HOLD: state returns to RUN and scoreboard clears immediately. First post-reset edge runs normally.
- Load-use stall: exactly 1 cycle. Redirect penalty: FLUSH_CYCLES cycles of squashed IF/ID plus 1 bubble in ID/EX.

## Test plan

- Load-use: LW x5 issued, next ID ADD x6,x5,x1 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1; following cycle fwd_a=10, pc_en=1.
- Forward priority: ADDI x3 in MEM slot, ADDI x3 in EX slot, ID uses rs1=x3 -> fwd_a=01. Repeat with EX slot holding x4 -> fwd_a=10.
- x0 and unused sources: ID rs1=x0 with EX writer rd=x0, and LUI (rs1_used=0) matching EX rd -> fwd=00, no stall.
- Redirect with FLUSH_CYCLES=2: ex_redirect pulse -> ifid_flush=1 and idex_bubble=1 for 2 cycles, pc_en=1 throughout, back to RUN. Same cycle as a load-use match -> no stall asserted.
- Cache miss: mem_busy high 4 cycles during FLUSH (cnt=1) -> all enables 0, flush 0, scoreboard unchanged. After release, 1 remaining flush cycle, then RUN.
- Reset mid-operation: rst_n low while in FLUSH with valid slots -> outputs take reset values immediately. After release, state is RUN, slots empty and fwd=00.
